// File: rtl/image_write_scheduler.sv
// Ping-pong buffer between the IDCT and the Image Generator.
// Issues one start pulse per stored table and holds that table for the 64-cycle write burst.
module image_write_scheduler #(
  parameter int unsigned IMAGE_WIDTH  = 320,
  parameter int unsigned IMAGE_HEIGHT = 240,
  parameter int unsigned PIXEL_WIDTH  = 8,
  parameter int unsigned TABLE_SIZE   = 64,
  localparam int unsigned TW          = TABLE_SIZE * PIXEL_WIDTH,
  localparam int unsigned BLOCK_COUNT = IMAGE_WIDTH * IMAGE_HEIGHT / TABLE_SIZE,
  localparam int unsigned BCW         = $clog2(BLOCK_COUNT + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [TW-1:0]  in_table,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [TW-1:0]  gen_table,
  output logic           gen_start,
  output logic           busy,
  output logic [BCW-1:0] block_count,
  output logic           frame_done
);

  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, START, BURST} state_t;

  state_t          state;
  logic [TW-1:0]   slot [2];
  logic            wr_ptr;
  logic            rd_ptr;
  logic [1:0]      occ;
  logic [1:0]      occ_next;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign in_ready  = rst & (occ != 2'd2);
  assign push      = in_valid & in_ready;
  assign pop       = (state == BURST) && (cnt == CW'(63));
  // The slot under rd_ptr is never the write target while a table is in flight.
  assign gen_table = slot[rd_ptr];
  assign busy      = (state != IDLE) || (occ != 2'd0);

  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      slot[0]     <= '0;
      slot[1]     <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      occ         <= 2'd0;
      cnt         <= '0;
      gen_start   <= 1'b0;
      block_count <= '0;
      frame_done  <= 1'b0;
    end else begin
      gen_start  <= 1'b0;
      frame_done <= 1'b0;
      occ        <= occ_next;
      if (push) begin
        slot[wr_ptr] <= in_table;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;

      case (state)
        IDLE: begin
          if (occ != 2'd0) begin
            state     <= START;
            gen_start <= 1'b1;
          end
        end
        START: begin
          state <= BURST;
          cnt   <= '0;
        end
        BURST: begin
          cnt <= cnt + CW'(1);
          if (pop) begin
            // Wrap with the Image Generator's raster index at the frame end.
            if (block_count == BCW'(BLOCK_COUNT - 1)) begin
              block_count <= '0;
              frame_done  <= 1'b1;
            end else begin
              block_count <= block_count + BCW'(1);
            end
            if (occ_next != 2'd0) begin
              state     <= START;
              gen_start <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
